// File: rtl/ec_point_mult.sv
// Scalar multiplication R = k*G on y^2 = x^3 + A*x + b over GF(P), using left-to-right double-and-add with Fermat inversion.
// Optional macro EC_REDUCE_K_EN: LOAD reduces k mod ORDER (one extra cycle, only when k >= ORDER).
module ec_point_mult #(
  parameter int NR_BITI = 16,
  parameter int P       = 29,
  parameter int A       = 4,
  parameter int ORDER   = 37
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               start,
  input  logic [NR_BITI-1:0] k,
  input  logic [NR_BITI-1:0] gx,
  input  logic [NR_BITI-1:0] gy,
  output logic               busy,
  output logic               done,
  output logic [NR_BITI-1:0] rx,
  output logic [NR_BITI-1:0] ry,
  output logic               r_inf
);

  typedef logic [NR_BITI-1:0] fe_t;
  typedef enum logic [2:0] {IDLE, LOAD, DBL, ADD, INV, FIN} state_t;

  localparam int W1 = NR_BITI + 1;
  localparam int W2 = 2 * NR_BITI;
  localparam int IW = $clog2(NR_BITI);
  localparam int EW = $clog2(P);
  localparam logic [W1-1:0] P1  = W1'(P);
  localparam logic [W2-1:0] PP  = W2'(P);
  localparam fe_t           AF  = fe_t'(A);
  localparam fe_t           EXP = fe_t'(P - 2);
`ifdef EC_REDUCE_K_EN
  localparam fe_t           KO  = fe_t'(ORDER);
`endif

  if (P < 3 || ORDER < 2 || A >= P) begin : g_param_chk
    $error("ec_point_mult: invalid curve parameters");
  end

  function automatic fe_t mmul(input fe_t a, input fe_t b);
    return fe_t'(({{NR_BITI{1'b0}}, a} * {{NR_BITI{1'b0}}, b}) % PP);
  endfunction

  function automatic fe_t madd(input fe_t a, input fe_t b);
    logic [W1-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= P1) ? fe_t'(s - P1) : fe_t'(s);
  endfunction

  function automatic fe_t msub(input fe_t a, input fe_t b);
    return (a >= b) ? a - b : fe_t'({1'b0, a} + P1 - {1'b0, b});
  endfunction

  state_t        state_q, ret_q, cont_st_d;
  logic          ph_q, inf_q, busy_q, done_q, rinf_q;
  fe_t           k_q, gx_q, gy_q, x_q, y_q, ox_q, num_q, den_q, inv_q, rx_q, ry_q;
  logic [IW-1:0] idx_q, eidx_q, idx_nx_d;
  fe_t           xx_d, dnum_d, dden_d, lam_d, x3_d, y3_d;
  logic          take_add_d;

  // Doubling numerator/denominator and the shared chord/tangent finish once inv_q holds 1/den.
  always_comb begin
    xx_d       = mmul(x_q, x_q);
    dnum_d     = madd(madd(madd(xx_d, xx_d), xx_d), AF);
    dden_d     = madd(y_q, y_q);
    lam_d      = mmul(num_q, inv_q);
    x3_d       = msub(msub(mmul(lam_d, lam_d), x_q), ox_q);
    y3_d       = msub(mmul(lam_d, msub(x_q, x3_d)), y_q);
    take_add_d = (state_q == DBL) && k_q[idx_q];
    cont_st_d  = take_add_d ? ADD : ((idx_q == '0) ? FIN : DBL);
    idx_nx_d   = (take_add_d || idx_q == '0) ? idx_q : idx_q - 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;  ret_q  <= DBL;  ph_q   <= 1'b0;  inf_q  <= 1'b1;
      busy_q  <= 1'b0;  done_q <= 1'b0; rinf_q <= 1'b1;
      k_q  <= '0; gx_q <= '0; gy_q <= '0; x_q   <= '0; y_q  <= '0; ox_q <= '0;
      num_q <= '0; den_q <= '0; inv_q <= '0; rx_q <= '0; ry_q <= '0;
      idx_q <= '0; eidx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          k_q <= k; gx_q <= gx; gy_q <= gy;
          idx_q <= IW'(NR_BITI - 1); inf_q <= 1'b1; ph_q <= 1'b0;
          busy_q <= 1'b1; state_q <= LOAD;
        end
        LOAD: begin
`ifdef EC_REDUCE_K_EN
          if (k_q >= KO) k_q <= k_q % KO;
          else
`endif
          if (k_q == '0) state_q <= FIN;
          else if (k_q[idx_q]) state_q <= DBL;
          else idx_q <= idx_q - 1'b1;
        end
        DBL: begin
          if (ph_q) begin
            x_q <= x3_d; y_q <= y3_d; ph_q <= 1'b0;
            state_q <= cont_st_d; idx_q <= idx_nx_d;
          end else if (inf_q || y_q == '0) begin
            inf_q <= 1'b1; state_q <= cont_st_d; idx_q <= idx_nx_d;
          end else begin
            num_q <= dnum_d; den_q <= dden_d; ox_q <= x_q; ret_q <= DBL;
            inv_q <= fe_t'(1); eidx_q <= IW'(EW - 1); state_q <= INV;
          end
        end
        ADD: begin
          if (ph_q) begin
            x_q <= x3_d; y_q <= y3_d; ph_q <= 1'b0;
            state_q <= cont_st_d; idx_q <= idx_nx_d;
          end else if (inf_q) begin
            x_q <= gx_q; y_q <= gy_q; inf_q <= 1'b0;
            state_q <= cont_st_d; idx_q <= idx_nx_d;
          end else if (x_q == gx_q && madd(y_q, gy_q) == '0) begin
            inf_q <= 1'b1; state_q <= cont_st_d; idx_q <= idx_nx_d;
          end else begin
            // Equal x with non-negated y means R == G: fall onto the tangent.
            if (x_q == gx_q) begin
              num_q <= dnum_d; den_q <= dden_d; ox_q <= x_q;
            end else begin
              num_q <= msub(gy_q, y_q); den_q <= msub(gx_q, x_q); ox_q <= gx_q;
            end
            ret_q <= ADD; inv_q <= fe_t'(1); eidx_q <= IW'(EW - 1); state_q <= INV;
          end
        end
        INV: begin
          inv_q <= mmul(mmul(inv_q, inv_q), EXP[eidx_q] ? den_q : fe_t'(1));
          if (eidx_q == '0) begin
            state_q <= ret_q; ph_q <= 1'b1;
          end else begin
            eidx_q <= eidx_q - 1'b1;
          end
        end
        FIN: begin
          rx_q <= inf_q ? '0 : x_q; ry_q <= inf_q ? '0 : y_q; rinf_q <= inf_q;
          done_q <= 1'b1; busy_q <= 1'b0; state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rx    = rx_q;
  assign ry    = ry_q;
  assign r_inf = rinf_q;

endmodule

// File: tb/tb_ec_point_mult.sv
// Directed bench for ec_point_mult on y^2 = x^3 + 4x + 20 over GF(29), G = (1,5), order 37.
module tb_ec_point_mult;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] k = '0, gx = '0, gy = '0;
  logic         busy, done, r_inf;
  logic [W-1:0] rx, ry;
  int           n_vec = 0, n_bad = 0;

  ec_point_mult dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start), .k(k), .gx(gx), .gy(gy),
    .busy(busy), .done(done), .rx(rx), .ry(ry), .r_inf(r_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] kk, output logic b1, output int lat);
    @(negedge clk); k = kk; gx = 16'd1; gy = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0; b1 = busy; lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk); lat++;
    end
  endtask

  typedef struct {logic [W-1:0] k, x, y; logic inf;} vec_t;
  vec_t tv[11] = '{
    '{16'd1,  16'd1,  16'd5,  1'b0}, '{16'd2,  16'd4,  16'd19, 1'b0},
    '{16'd3,  16'd20, 16'd3,  1'b0}, '{16'd36, 16'd1,  16'd24, 1'b0},
    '{16'd35, 16'd4,  16'd10, 1'b0}, '{16'd34, 16'd20, 16'd26, 1'b0},
    '{16'd37, 16'd0,  16'd0,  1'b1}, '{16'd0,  16'd0,  16'd0,  1'b1},
    '{16'd38, 16'd1,  16'd5,  1'b0}, '{16'd75, 16'd1,  16'd5,  1'b0},
    '{16'd74, 16'd0,  16'd0,  1'b1}
  };

  initial begin
    logic b1, stable;
    int   lat, lat1, lat38, ndone;
    lat1 = 0; lat38 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0); chk("rst done", done, 0);
    chk("rst rx", rx, 0); chk("rst ry", ry, 0); chk("rst r_inf", r_inf, 1);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run(tv[i].k, b1, lat);
      chk($sformatf("k=%0d busy", tv[i].k), b1, 1);
      chk($sformatf("k=%0d done", tv[i].k), done, 1);
      chk($sformatf("k=%0d rx", tv[i].k), rx, tv[i].x);
      chk($sformatf("k=%0d ry", tv[i].k), ry, tv[i].y);
      chk($sformatf("k=%0d r_inf", tv[i].k), r_inf, tv[i].inf);
      chk($sformatf("k=%0d latency bound", tv[i].k), (lat <= 292), 1);
      if (tv[i].k == 16'd1) lat1 = lat;
      if (tv[i].k == 16'd38) lat38 = lat;
      @(negedge clk);
      chk($sformatf("k=%0d done width", tv[i].k), done, 0);
      chk($sformatf("k=%0d held rx", tv[i].k), rx, tv[i].x);
    end
`ifdef EC_REDUCE_K_EN
    chk("lat k38 vs k1", lat38, lat1 + 1);
`else
    chk("lat k38 longer", (lat38 > lat1), 1);
`endif

    // Asynchronous reset in the middle of an operation
    @(negedge clk); k = 16'd20; gx = 16'd1; gy = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", busy, 0); chk("async r_inf", r_inf, 1);
    chk("async rx", rx, 0); chk("async done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no done after reset", ndone, 0);
    run(16'd2, b1, lat);
    chk("post-rst done", done, 1); chk("post-rst rx", rx, 4); chk("post-rst ry", ry, 19);

    // Start held high while busy: only the first request counts
    @(negedge clk); k = 16'd3; gx = 16'd1; gy = 16'd5; start = 1'b1;
    stable = 1'b1; lat = 0;
    @(negedge clk);
    while (done !== 1'b1 && lat < 400) begin
      k = 16'd5 + 16'(lat);
      if (rx !== 16'd4 || ry !== 16'd19) stable = 1'b0;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    chk("hammer done", done, 1); chk("hammer stable", stable, 1);
    chk("hammer rx", rx, 20); chk("hammer ry", ry, 3);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("hammer extra done", ndone, 0); chk("hammer idle busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ec_point_mult.md
EC_POINT_MULT -- requirements
Module: ec_point_mult

Interface
REQ-001 Parameter NR_BITI, default 16, width of the scalar, coordinates and modulus.
REQ-002 Parameter P, default 29, prime field modulus.
REQ-003 Parameter A, default 4, curve coefficient a of y^2 = x^3 + a*x + b (b unused by arithmetic).
REQ-004 Parameter ORDER, default 37, group order of the generator.
REQ-005 CLK100MHZ  input  1  single clock; all state updates on its rising edge.
REQ-006 CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request; samples k, gx, gy.
REQ-008 k  input  NR_BITI  unsigned scalar.
REQ-009 gx, gy  input  NR_BITI each  base point, both in [0, P-1].
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 rx, ry  output  NR_BITI each  result coordinates; held until the next accepted start.
REQ-013 r_inf  output  1  result is the point at infinity (rx = ry = 0).

Function
REQ-014 States: IDLE, LOAD, DBL, ADD, INV, FIN; reset enters IDLE.
REQ-015 IDLE: start=1 -> LOAD, latches k, gx, gy; start while busy is ignored.
REQ-016 LOAD: accumulator R = infinity; bit index = NR_BITI-1; skips leading zero bits at one bit per cycle.
REQ-017 Left-to-right double-and-add: per bit, R = 2R (DBL), then R = R + G (ADD) if the bit is 1.
REQ-018 k = 0, or all bits consumed -> FIN, done=1 for exactly one cycle, then IDLE.
REQ-019 Modular multiply: single-cycle full product reduced with % P; add/sub results normalised to [0, P-1].
REQ-020 Modular inverse: INV sub-state computes z^(P-2) mod P by square-and-multiply, one exponent bit per cycle; returns to the calling DBL/ADD.
REQ-021 DBL: R = infinity or y = 0 -> infinity; otherwise lambda = (3x^2 + A) * inv(2y), x3 = lambda^2 - 2x, y3 = lambda(x - x3) - y.
REQ-022 ADD: R = infinity -> R = G; x equal with y sum = 0 mod P -> infinity; R = G -> doubling path; otherwise lambda = (y2 - y1) * inv(x2 - x1).
REQ-023 Latency is data-dependent; the upper bound is NR_BITI * 2 * (ceil(log2 P) + 4) + 4 cycles from start to done.
REQ-024 rx, ry, r_inf update only in FIN.

Reset
REQ-025 CPU_RESETN low forces IDLE immediately, in any state including mid-operation; busy=0, done=0, rx=0, ry=0, r_inf=1.
REQ-026 No partial result is emitted after reset; the first start after reset release is accepted normally.

Configuration
REQ-027 Macro EC_REDUCE_K_EN defined: LOAD replaces k with k mod ORDER before scanning (one extra cycle); k = ORDER -> infinity without scanning.
REQ-028 EC_REDUCE_K_EN undefined: k is scanned unmodified; results are identical modulo the group law, with longer latency.

Verification
REQ-029 k=1, G=(1,5) -> done pulse, rx=1, ry=5, r_inf=0.
REQ-030 k=2, G=(1,5) -> rx=4, ry=19.
REQ-031 k=36, G=(1,5) -> rx=1, ry=24; k=37 -> r_inf=1, rx=ry=0; k=0 -> r_inf=1.
REQ-032 EC_REDUCE_K_EN defined, k=38 -> (1,5) with same latency as k=1 plus one cycle; undefined, k=38 -> still (1,5).
REQ-033 Start k=20, CPU_RESETN pulsed low mid-DBL -> busy=0 and r_inf=1 asynchronously, no done pulse; then start k=2 -> (4,19).
REQ-034 Start reasserted every cycle while busy -> ignored; exactly one done per accepted start, and outputs stable between dones.
